freq_governor: RTL and testbench

- Parametrised successor to the single-counter tick block.
- Free-running tick counter with enable and clear; per-window peak occupancy tracking across NUM_CH queues.
- Selects one of NUM_LEVELS core-clock levels using up-thresholds, step-down hysteresis and minimum dwell.
- Drives the one-hot clock-choice lines consumed by the clock-mux logic; the register-chain block exports counters and takes config.

---
 rtl/freq_gov_pkg.sv | 24 ++
 rtl/occ_max_tree.sv | 18 +
 rtl/freq_governor.sv | 141 ++++++++++++++
 tb/tb_freq_governor.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/freq_gov_pkg.sv
// Shared definitions for the core-clock frequency governor: level encodings,
// a constant-safe clog2 and the default up-threshold table.
package freq_gov_pkg;

   typedef enum logic [1:0] {
      LVL_50   = 2'd0,
      LVL_62_5 = 2'd1,
      LVL_83   = 2'd2,
      LVL_125  = 2'd3
   } freq_level_e;

   localparam int DEF_OCC_W = 32;
   localparam logic [3*DEF_OCC_W-1:0] DEF_UP_THRESH = {32'd3000, 32'd2000, 32'd1000};

   // Never returns less than 1 so that single-entry counters keep a real bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/occ_max_tree.sv
// Combinational unsigned maximum across NUM_CH packed occupancy values.
module occ_max_tree #(
   parameter int NUM_CH    = 4,
   parameter int OCC_WIDTH = 32
) (
   input  logic [NUM_CH*OCC_WIDTH-1:0] occ_in,
   output logic [OCC_WIDTH-1:0]        occ_max
);

   always_comb begin
      occ_max = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (occ_in[i*OCC_WIDTH +: OCC_WIDTH] > occ_max)
            occ_max = occ_in[i*OCC_WIDTH +: OCC_WIDTH];
      end
   end

endmodule

// File: rtl/freq_governor.sv
// Windowed peak-occupancy tracker that picks a core-clock level with
// up-thresholds, single-step hysteretic step-down and a minimum dwell.
module freq_governor
   import freq_gov_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int OCC_WIDTH   = 32,
   parameter int CNT_WIDTH   = 32,
   parameter int WINDOW_LOG2 = 10,
   parameter int NUM_LEVELS  = 4,
   parameter int DWELL_WIN   = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              enable_ticks,
   input  logic                              reset_ticks,
   input  logic [NUM_CH*OCC_WIDTH-1:0]       occ_in,
   input  logic [(NUM_LEVELS-1)*OCC_WIDTH-1:0] up_thresh,
   input  logic [OCC_WIDTH-1:0]              hyst,
   output logic [CNT_WIDTH-1:0]              tick_count,
   output logic [OCC_WIDTH-1:0]              peak_last,
   output logic                              window_done,
   output logic [clog2(NUM_LEVELS)-1:0]      level,
   output logic [NUM_LEVELS-1:0]             choice,
   output logic [15:0]                       switch_count
);

   localparam int LVL_W   = clog2(NUM_LEVELS);
   localparam int DWELL_W = clog2(DWELL_WIN + 1);
   localparam logic [CNT_WIDTH-1:0] WIN_MASK = CNT_WIDTH'((64'd1 << WINDOW_LOG2) - 64'd1);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [OCC_WIDTH-1:0] sample_max_p0;
   logic [OCC_WIDTH-1:0] run_peak_p0;
   logic [OCC_WIDTH-1:0] peak_in_p0;
   logic                 win_close_p0;
   logic                 vld_p1;

   occ_max_tree #(
      .NUM_CH    (NUM_CH),
      .OCC_WIDTH (OCC_WIDTH)
   ) u_max (
      .occ_in  (occ_in),
      .occ_max (sample_max_p0)
   );

   assign peak_in_p0   = (sample_max_p0 > run_peak_p0) ? sample_max_p0 : run_peak_p0;
   assign win_close_p0 = enable_ticks && !reset_ticks && ((tick_count & WIN_MASK) == WIN_MASK);

   // ---- p0 -> p1: tick counter, running peak, window close ----
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_count  <= '0;
         run_peak_p0 <= '0;
         peak_last   <= '0;
         vld_p1      <= 1'b0;
      end else begin
         vld_p1 <= 1'b0;
         if (reset_ticks) begin
            tick_count  <= '0;
            run_peak_p0 <= '0;
         end else if (enable_ticks) begin
            tick_count <= tick_count + 1'b1;
            if (win_close_p0) begin
               peak_last   <= peak_in_p0;
               run_peak_p0 <= '0;
               vld_p1      <= 1'b1;
            end else begin
               run_peak_p0 <= peak_in_p0;
            end
         end
      end
   end

   assign window_done = vld_p1;

   logic [LVL_W-1:0]     level_q, level_d, target_p1;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [15:0]          switch_d;
   logic [OCC_WIDTH-1:0] thr_cur_p1;
   logic [OCC_WIDTH:0]   head_sum_p1;
   logic                 change_p1;

   always_comb begin
      target_p1  = '0;
      thr_cur_p1 = '0;
      for (int k = 1; k < NUM_LEVELS; k++) begin
         if (peak_last >= up_thresh[(k-1)*OCC_WIDTH +: OCC_WIDTH]) target_p1 = LVL_W'(k);
         if (level_q == LVL_W'(k)) thr_cur_p1 = up_thresh[(k-1)*OCC_WIDTH +: OCC_WIDTH];
      end
   end

   // Extra bit keeps peak+hyst from wrapping past the threshold.
   assign head_sum_p1 = {1'b0, peak_last} + {1'b0, hyst};

   always_comb begin
      level_d   = level_q;
      dwell_d   = dwell_q;
      switch_d  = switch_count;
      change_p1 = 1'b0;
      if (vld_p1) begin
         if (dwell_q != '0) begin
            dwell_d = dwell_q - 1'b1;
         end else if (target_p1 > level_q) begin
            level_d   = target_p1;
            change_p1 = 1'b1;
         end else if ((target_p1 < level_q) && (head_sum_p1 < {1'b0, thr_cur_p1})) begin
            level_d   = level_q - 1'b1;
            change_p1 = 1'b1;
         end
         if (change_p1) begin
            dwell_d  = DWELL_W'(DWELL_WIN);
            switch_d = sat_inc16(switch_count);
         end
      end
   end

   // ---- p1 -> p2: level decision register ----
   always_ff @(posedge clk) begin
      if (reset) begin
         level_q      <= LVL_W'(NUM_LEVELS - 1);
         dwell_q      <= '0;
         switch_count <= '0;
      end else begin
         level_q      <= level_d;
         dwell_q      <= dwell_d;
         switch_count <= switch_d;
      end
   end

   always_comb begin
      choice = '0;
      for (int k = 0; k < NUM_LEVELS; k++) choice[k] = (level_q == LVL_W'(k));
   end

   assign level = level_q;

endmodule

// File: tb/tb_freq_governor.sv
// Scoreboard bench: stimulus pushes per-window expectations, a monitor pops
// them on window_done; a second small instance covers wrap and saturation.
module tb_freq_governor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic         en_m, rt_m;
   logic [127:0] occ_m;
   logic [95:0]  thr_m;
   logic [31:0]  hyst_m;
   logic [31:0]  tick_m, peak_m;
   logic         wd_m;
   logic [1:0]   lvl_m;
   logic [3:0]   ch_m;
   logic [15:0]  sc_m;

   logic         en_w;
   logic [31:0]  occ_w;
   logic [15:0]  thr_w, hyst_w;
   logic [7:0]   tick_w;
   logic [15:0]  peak_w;
   logic         wd_w;
   logic [0:0]   lvl_w;
   logic [1:0]   ch_w;
   logic [15:0]  sc_w;

   freq_governor #(
      .NUM_CH(4), .OCC_WIDTH(32), .CNT_WIDTH(32),
      .WINDOW_LOG2(4), .NUM_LEVELS(4), .DWELL_WIN(2)
   ) u_main (
      .clk(clk), .reset(reset), .enable_ticks(en_m), .reset_ticks(rt_m),
      .occ_in(occ_m), .up_thresh(thr_m), .hyst(hyst_m),
      .tick_count(tick_m), .peak_last(peak_m), .window_done(wd_m),
      .level(lvl_m), .choice(ch_m), .switch_count(sc_m)
   );

   freq_governor #(
      .NUM_CH(2), .OCC_WIDTH(16), .CNT_WIDTH(8),
      .WINDOW_LOG2(0), .NUM_LEVELS(2), .DWELL_WIN(0)
   ) u_wrap (
      .clk(clk), .reset(reset), .enable_ticks(en_w), .reset_ticks(1'b0),
      .occ_in(occ_w), .up_thresh(thr_w), .hyst(hyst_w),
      .tick_count(tick_w), .peak_last(peak_w), .window_done(wd_w),
      .level(lvl_w), .choice(ch_w), .switch_count(sc_w)
   );

   typedef struct {
      int unsigned peak;
      int unsigned lvl;
      int unsigned sc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned exp_tick;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_occ(input int unsigned v);
      for (int c = 0; c < 4; c++) occ_m[c*32 +: 32] = v;
   endtask

   task automatic run_window(input int unsigned steady, input int pulse_ch, input int unsigned pulse_val,
                             input int unsigned e_peak, input int unsigned e_lvl, input int unsigned e_sc);
      for (int t = 0; t < 16; t++) begin
         check("tick_count", tick_m, exp_tick);
         set_occ(steady);
         if (pulse_ch >= 0 && t == 7) occ_m[pulse_ch*32 +: 32] = pulse_val;
         en_m = 1'b1;
         if (t == 15) sb.push_back('{e_peak, e_lvl, e_sc});
         step();
         exp_tick++;
      end
   endtask

   initial begin : monitor
      exp_t        e;
      int unsigned prev_lvl;
      prev_lvl = 3;
      forever begin
         @(negedge clk);
         if (wd_m === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_window_done", wd_m, 0);
            end else begin
               e = sb.pop_front();
               check("peak_last", peak_m, e.peak);
               check("level_before_decision", lvl_m, prev_lvl);
               @(negedge clk);
               check("window_done_pulse", wd_m, 0);
               check("level", lvl_m, e.lvl);
               check("choice", ch_m, 64'd1 << e.lvl);
               check("switch_count", sc_m, e.sc);
               prev_lvl = e.lvl;
            end
         end
      end
   end

   initial begin
      reset  = 1'b1;
      en_m   = 1'b0;
      rt_m   = 1'b0;
      occ_m  = '0;
      thr_m  = {32'd3000, 32'd2000, 32'd1000};
      hyst_m = 32'd200;
      en_w   = 1'b0;
      occ_w  = '0;
      thr_w  = 16'd1000;
      hyst_w = 16'd0;
      exp_tick = 0;
      repeat (3) step();

      check("rst_tick_count", tick_m, 0);
      check("rst_peak_last", peak_m, 0);
      check("rst_window_done", wd_m, 0);
      check("rst_level", lvl_m, 3);
      check("rst_choice", ch_m, 4'b1000);
      check("rst_switch_count", sc_m, 0);
      check("rst_wrap_choice", ch_w, 2'b10);

      reset = 1'b0;
      step();
      check("idle_tick_count", tick_m, 0);

      // Step-down from fastest with dwell of two windows after each change.
      run_window(0, -1, 0, 0, 2, 1);
      run_window(0, -1, 0, 0, 2, 1);
      run_window(0, -1, 0, 0, 2, 1);
      run_window(0, -1, 0, 0, 1, 2);
      run_window(0, -1, 0, 0, 1, 2);
      run_window(0, -1, 0, 0, 1, 2);
      run_window(0, -1, 0, 0, 0, 3);
      run_window(0, -1, 0, 0, 0, 3);
      run_window(0, -1, 0, 0, 0, 3);
      // Single-cycle burst jumps two levels at once.
      run_window(0, 2, 2500, 2500, 2, 4);
      run_window(1900, -1, 0, 1900, 2, 4);
      run_window(1900, -1, 0, 1900, 2, 4);
      run_window(1900, -1, 0, 1900, 2, 4);
      run_window(1700, -1, 0, 1700, 1, 5);

      // reset_ticks at tick 9 discards the 5000 peak and restarts the window.
      for (int t = 0; t < 10; t++) begin
         check("tick_count", tick_m, exp_tick);
         set_occ(5000);
         en_m = 1'b1;
         rt_m = (t == 9);
         step();
         exp_tick = (t == 9) ? 0 : exp_tick + 1;
      end
      rt_m = 1'b0;
      check("tick_after_reset_ticks", tick_m, 0);
      run_window(500, -1, 0, 500, 1, 5);

      // Freeze mid-window; large occupancy while disabled must be ignored.
      for (int t = 0; t < 8; t++) begin
         check("tick_count", tick_m, exp_tick);
         set_occ(600);
         en_m = 1'b1;
         step();
         exp_tick++;
      end
      en_m = 1'b0;
      set_occ(9000);
      for (int t = 0; t < 20; t++) begin
         step();
         check("tick_frozen", tick_m, exp_tick);
      end
      for (int t = 0; t < 8; t++) begin
         check("tick_count", tick_m, exp_tick);
         set_occ(600);
         en_m = 1'b1;
         if (t == 7) sb.push_back('{600, 1, 5});
         step();
         exp_tick++;
      end

      // Decision still lands when ticks are disabled right after the close.
      run_window(0, -1, 0, 0, 0, 6);
      en_m = 1'b0;
      repeat (6) step();
      check("scoreboard_drained", sb.size(), 0);
      check("final_choice", ch_m, 4'b0001);

      // Wrap instance: one-tick windows, no dwell, alternating 0 / 2000.
      for (int i = 0; i < 300; i++) begin
         if (i == 255) check("tick_wrap_255", tick_w, 255);
         if (i == 256) check("tick_wrap_0", tick_w, 0);
         occ_w = (i % 2 == 1) ? {16'd2000, 16'd0} : 32'd0;
         en_w  = 1'b1;
         step();
      end
      en_w = 1'b0;
      step();
      check("wrap_switch_300", sc_w, 300);
      check("wrap_level", lvl_w, 1);
      check("wrap_peak_last", peak_w, 2000);
      for (int i = 0; i < 69700; i++) begin
         occ_w = (i % 2 == 1) ? {16'd2000, 16'd0} : 32'd0;
         en_w  = 1'b1;
         step();
      end
      en_w = 1'b0;
      repeat (2) step();
      check("switch_saturated", sc_w, 16'hFFFF);
      check("sat_level", lvl_w, 1);
      check("sat_choice", ch_w, 2'b10);
      check("sat_window_idle", wd_w, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
